// File: rtl/uart_byte_packer.sv
// uart_byte_packer: packs a UART byte stream LSB-first into one wide word with a valid/ready hand-off
//   clk, rstn         : clock, asynchronous active-low reset
//   s_valid, s_data   : byte strobe and byte from the UART receiver (no back-pressure at source)
//   s_ready           : high while filling, i.e. a byte can be taken this cycle
//   m_valid, m_ready  : word hand-off to the multiplier; m_data held stable while m_valid
//   m_data            : assembled word, byte 0 in the least significant slot
//   overrun           : sticky, a byte arrived while s_ready was low
//   drop              : one-cycle pulse, a partial word was discarded on inter-byte timeout
// Optional: `define UART_PACKER_TIMEOUT_EN builds the inter-byte timeout; otherwise drop is 0.
module uart_byte_packer #(
    parameter int BITS_PER_WORD = 8,
    parameter int W_OUT         = 576,
    parameter int TIMEOUT_CLKS  = 100_000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    input  logic [BITS_PER_WORD-1:0] s_data,
    output logic                     s_ready,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [W_OUT-1:0]         m_data,
    output logic                     overrun,
    output logic                     drop
);
    localparam int N  = W_OUT / BITS_PER_WORD;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
`ifdef UART_PACKER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    logic [CW-1:0] cnt_q;
`endif
    typedef enum logic {FILL, FULL} state_t;
    state_t            state_q;
    logic [IW-1:0]     idx_q;
    logic [W_OUT-1:0]  data_q;
    logic              ovr_q;
    logic              drop_q;
    assign s_ready = (state_q == FILL);
    assign m_valid = (state_q == FULL);
    assign m_data  = data_q;
    assign overrun = ovr_q;
    assign drop    = drop_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FILL;
            idx_q   <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
            drop_q  <= 1'b0;
`ifdef UART_PACKER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            drop_q <= 1'b0;
            if (s_valid && !s_ready)
                ovr_q <= 1'b1;
            case (state_q)
                FILL: begin
                    if (s_valid) begin
                        data_q[int'(idx_q)*BITS_PER_WORD +: BITS_PER_WORD] <= s_data;
                        idx_q   <= (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
                        state_q <= (idx_q == IW'(N - 1)) ? FULL : FILL;
`ifdef UART_PACKER_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
`ifdef UART_PACKER_TIMEOUT_EN
                    // a byte on the timeout cycle takes the branch above, so it wins
                    else if (idx_q != '0) begin
                        if (cnt_q == CW'(TIMEOUT_CLKS - 1)) begin
                            idx_q  <= '0;
                            cnt_q  <= '0;
                            drop_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
`endif
                end
                FULL: begin
                    if (m_ready)
                        state_q <= FILL;
                end
                default: state_q <= FILL;
            endcase
        end
    end
endmodule

// File: doc/uart_byte_packer.md
# uart_byte_packer

Assembles the byte stream from the UART receiver's byte-level front end into one wide word (weights plus input vector) and hands it to the matrix-vector multiplier over a valid/ready handshake. It sits directly upstream of the multiplier's `kx` slave port. It holds each complete word until the multiplier accepts it, and it flags bytes lost to back-pressure. An optional inter-byte timeout discards a partial word so the packer resynchronises after a line glitch.

## Interface
Parameters:
- `BITS_PER_WORD`, 8: width of one incoming byte.
- `W_OUT`, 576: output word width; must be an integer multiple of `BITS_PER_WORD` (576 = 8·8·8 + 8·8).
- `TIMEOUT_CLKS`, 100_000: idle clocks allowed between bytes of one word before the partial word is dropped.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  byte strobe from the UART byte receiver; single-cycle pulse; no back-pressure at the source.
- `s_data`  in  `BITS_PER_WORD`  received byte.
- `s_ready`  out  1  packer can accept a byte this cycle.
- `m_valid`  out  1  `m_data` holds a complete word.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  `W_OUT`  assembled word.
- `overrun`  out  1  sticky; a byte arrived while `s_ready` was 0.
- `drop`  out  1  one-cycle pulse; a partial word was discarded by timeout.

## Operation
- `N = W_OUT/BITS_PER_WORD` bytes per word. Byte index `idx` counts 0..N-1.
- The first byte received lands in `m_data[BITS_PER_WORD-1:0]`. Byte `i` lands in bits `[BITS_PER_WORD*(i+1)-1 : BITS_PER_WORD*i]`. Ordering is LSB first (little-endian).
- The state machine has two states, FILL and FULL. Reset enters FILL with `idx=0`.
- FILL:
  - `s_ready=1` and `m_valid=0`.
  - When `s_valid=1`, the byte is written at `idx`.
  - If `idx==N-1`, `idx` returns to 0 and the state goes to FULL. Otherwise `idx` increments.
- FULL:
  - `s_ready=0` and `m_valid=1`; `m_data` is frozen.
  - When `m_valid && m_ready`, the transfer completes and the state returns to FILL on the next edge.
- Overrun:
  - Any `s_valid=1` while `s_ready=0` discards that byte and sets `overrun` to 1.
  - `overrun` clears only on reset.
- `m_data` bits outside the word's byte slots are never cleared between words. They are meaningful only while `m_valid=1`.
- Reset mid-word or mid-hold: all state is lost, the block returns to FILL with `idx=0`, and `m_valid` deasserts immediately (asynchronous).

## Timing
- Reset values:
  - `s_ready=1`
  - `m_valid=0`
  - `m_data=0`
  - `overrun=0`
  - `drop=0`
- All outputs are registered or decoded directly from state; there is no combinational path from `m_ready` or `s_valid` to any output.
- Latency: the last byte is sampled at edge k, and `m_valid=1` from edge k onward (first visible cycle is k+1).
- Handshake: once `m_valid` rises, it stays high and `m_data` stays stable until a cycle with `m_ready=1`. `m_valid` falls at the following edge.
- Minimum turnaround: after the transfer edge the block is in FILL, so it can accept the first byte of the next word one cycle after the handshake.
- A byte arriving in the same cycle as the handshake is dropped (`s_ready=0` in that cycle) and sets `overrun`.
- `drop` is a single cycle wide and is registered.

## Configuration
- `UART_PACKER_TIMEOUT_EN` defined:
  - An idle counter runs in FILL while `idx!=0`. It clears on every accepted byte and is held at 0 when `idx==0` and in FULL.
  - When it reaches `TIMEOUT_CLKS-1`, `idx` is reset to 0 and `drop` pulses on the next cycle.
  - If a byte arrives in the same cycle as the timeout, the byte wins: it is accepted at the current `idx` and the counter clears, with no drop.
- Not defined: no counter is built, `drop` is tied to 0, and a partial word waits indefinitely.

## Test plan
Bench configuration: `W_OUT=32`, `TIMEOUT_CLKS=16`, macro defined.
1. Reset check: hold `rstn=0`, then release. All outputs must be at their reset values and `s_ready=1`.
2. Basic word: send bytes 0x11, 0x22, 0x33, 0x44 with `m_ready=1`. Required: `m_data=0x44332211`, `m_valid` high for exactly 1 cycle, and `m_valid` rises one cycle after the 0x44 strobe.
3. Back-pressure: with `m_ready=0`, send 0xA1..0xA4, then send 0x55. Required: `m_data=0xA4A3A2A1` held stable and `overrun=1`. Then raise `m_ready`; `m_valid` must drop after 1 cycle.
4. Timeout: send 0x01, 0x02, then idle 20 cycles. Required: `drop` pulses once. Then send 0x10..0x40; required `m_data=0x40302010`.
5. Timeout boundary: send the next byte exactly on the timeout cycle. Required: no `drop`, and the byte is packed at its index.
6. Mid-word reset: assert `rstn=0` after 2 bytes. Required: `idx=0` afterwards, and the next four bytes form a clean word.
